// File: rtl/dec_n.sv
// rtl/dec_n.sv - registered one-hot decoder with direct-decode and auto-scan modes
//
// Optional feature macro: DEC_N_MASK_EN
//   defined   : port i_mask exists; masked indices are never driven (direct) or
//               shown (scan), and the scan steps over them without dwelling.
//   undefined : no i_mask port; every index is enabled.
//
// Parameters
//   IN_W     : select width (1..6); OUT_W = 2**IN_W one-hot lines
//   PRESCALE : scan dwell per index in clock cycles (1..255)
//
// Ports
//   i_clk   : clock, all state changes on the rising edge
//   i_rst   : asynchronous active-high reset
//   i_en    : block enable, 0 forces IDLE
//   i_mode  : 0 = direct decode, 1 = auto-scan
//   i_valid : direct-mode strobe qualifying i_in
//   i_in    : direct-mode select index
//   i_mask  : per-index disable (DEC_N_MASK_EN only)
//   o_out   : registered one-hot decode (or all zero)
//   o_idx   : index currently decoded
//   o_valid : o_out/o_idx hold a valid decode
//   o_wrap  : one-cycle pulse when the scan returns to a lower index
module dec_n #(
    parameter int IN_W     = 3,
    parameter int PRESCALE = 4,
    localparam int OUT_W   = 2**IN_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_in,
`ifdef DEC_N_MASK_EN
    input  logic [OUT_W-1:0] i_mask,
`endif
    output logic [OUT_W-1:0] o_out,
    output logic [IN_W-1:0]  o_idx,
    output logic             o_valid,
    output logic             o_wrap
);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(PRESCALE - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0] out_d;
    logic [IN_W-1:0]  idx_d;
    logic             valid_d;
    logic             wrap_d;
    logic [OUT_W-1:0] mask_v;
    logic [IN_W:0]    hit;

`ifdef DEC_N_MASK_EN
    assign mask_v = i_mask;
`else
    assign mask_v = '0;
`endif

    // First enabled index at or after 'start', searching circularly.
    // Result is {found, index}; found=0 when every index is masked.
    function automatic logic [IN_W:0] find_first(input logic [IN_W-1:0]  start,
                                                 input logic [OUT_W-1:0] m);
        logic [IN_W:0]   r;
        logic [IN_W-1:0] c;
        r = '0;
        // Walk backwards so the nearest candidate is the one left standing.
        for (int k = OUT_W - 1; k >= 0; k--) begin
            c = start + IN_W'(k);
            if (!m[c]) r = {1'b1, c};
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = o_out;
        idx_d   = o_idx;
        valid_d = o_valid;
        wrap_d  = 1'b0;
        hit     = '0;

        if (!i_en)       state_d = IDLE;
        else if (i_mode) state_d = SCAN;
        else             state_d = DIRECT;

        // Outputs are computed for the state being entered so that they
        // appear together with it on the following cycle.
        case (state_d)
            IDLE: begin
                cnt_d   = '0;
                out_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
            DIRECT: begin
                cnt_d = '0;
                if (i_valid) begin
                    idx_d = i_in;
                    if (mask_v[i_in]) begin
                        out_d   = '0;
                        valid_d = 1'b0;
                    end else begin
                        out_d   = OUT_W'(1) << i_in;
                        valid_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    cnt_d   = '0;
                    hit     = find_first('0, mask_v);
                    idx_d   = hit[IN_W-1:0];
                    valid_d = hit[IN_W];
                    out_d   = hit[IN_W] ? (OUT_W'(1) << hit[IN_W-1:0]) : '0;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    hit     = find_first(o_idx + IN_W'(1), mask_v);
                    idx_d   = hit[IN_W-1:0];
                    valid_d = hit[IN_W];
                    out_d   = hit[IN_W] ? (OUT_W'(1) << hit[IN_W-1:0]) : '0;
                    // Landing on the same or a lower index means the scan
                    // went round; covers the single-enabled-index case too.
                    wrap_d  = hit[IN_W] && (hit[IN_W-1:0] <= o_idx);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                out_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_out   <= '0;
            o_idx   <= '0;
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_out   <= out_d;
            o_idx   <= idx_d;
            o_valid <= valid_d;
            o_wrap  <= wrap_d;
        end
    end

endmodule
